mtsp_sync_requester: RTL

Core-side initiator of the multi-core synchronisation (barrier) handshake. It accepts a barrier request from the core's issue stage and emits a single-cycle `en` pulse on the core's `i_sync` link. It then stalls the core until the barrier releases with `ack`, and re-arms only after `ack` has returned low. One instance sits in each Meitner core, facing the system-level barrier synchroniser. It also counts completed barriers and flags timeouts and protocol errors.

---
 rtl/mtsp_sync_requester_if.sv | 16 +
 rtl/mtsp_sync_requester.sv | 104 ++++++++++
 2 files changed

// File: rtl/mtsp_sync_requester_if.sv
// Core <-> barrier synchroniser link: single-cycle en request,
// level ack release.
interface i_sync;
  logic en;
  logic ack;

  modport core (
    output en,
    input  ack
  );

  modport barrier (
    input  en,
    output ack
  );
endinterface

// File: rtl/mtsp_sync_requester.sv
// Core-side barrier initiator: pulses en, stalls until ack releases,
// counts completed barriers and flags watchdog/protocol errors.
module mtsp_sync_requester #(
  parameter int TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'hFFFF,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   req_valid,
  output logic                   req_ready,
  i_sync.core                    core_sync,
  output logic                   stall,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sync_count,
  output logic                   timeout_err,
  output logic                   protocol_err,
  input  logic                   err_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t                   state;
  logic                     ack_d;
  logic                     ack_rise;
  logic [TIMEOUT_WIDTH-1:0] wdog;
  logic [TIMEOUT_WIDTH-1:0] wdog_inc;
  logic                     wdog_run;

  assign ack_rise  = core_sync.ack & ~ack_d;
  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE);
  assign wdog_inc  = wdog + 1'b1;

  // Zero timeout disables the watchdog; otherwise saturate at the limit.
  assign wdog_run  = (TIMEOUT_CYCLES != '0) &&
                     (wdog != TIMEOUT_CYCLES);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= S_IDLE;
      core_sync.en <= 1'b0;
      done         <= 1'b0;
      sync_count   <= '0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
      ack_d        <= 1'b0;
      wdog         <= '0;
    end else begin
      ack_d <= core_sync.ack;

      // Clear first so a same-cycle set below takes priority.
      if (err_clr) begin
        timeout_err  <= 1'b0;
        protocol_err <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          done         <= 1'b0;
          core_sync.en <= req_valid;
          if (req_valid) begin
            wdog  <= '0;
            state <= S_WAIT;
          end
          if (ack_rise) begin
            protocol_err <= 1'b1;
          end
        end
        S_WAIT: begin
          core_sync.en <= 1'b0;
          if (wdog_run) begin
            wdog <= wdog_inc;
            if (wdog_inc == TIMEOUT_CYCLES) begin
              timeout_err <= 1'b1;
            end
          end
          if (ack_rise) begin
            done       <= 1'b1;
            sync_count <= sync_count + 1'b1;
            state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          core_sync.en <= 1'b0;
          done         <= 1'b0;
          if (!core_sync.ack) begin
            state <= S_IDLE;
          end
        end
        default: begin
          core_sync.en <= 1'b0;
          done         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
